clk_div_prog: RTL

Runtime-programmable integer clock divider, the parametrised successor to the fixed divide-by-4 generator. It derives a registered `clk_out` from `clk_in` with a ratio loaded at runtime, and supports odd ratios. Ratio changes and enable/disable take effect only at period boundaries, so `clk_out` never glitches. It feeds the SPI/flash serial clock path and provides a single-cycle `tick` strobe for logic that stays in the `clk_in` domain.

---
 rtl/clk_div_prog_pkg.sv | 17 +
 rtl/clk_div_prog.sv | 124 ++++++++++++
 2 files changed

// File: rtl/clk_div_prog_pkg.sv
// Shared types, constants and helpers for the programmable clock divider.
package clk_div_prog_pkg;

    localparam int unsigned DIV_MIN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    // Ratios below DIV_MIN cannot form a high and a low phase, so they are raised to DIV_MIN.
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with odd-ratio support.
// Ratio and enable changes are applied only at period boundaries, so clk_out never glitches.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DIV_DEFAULT = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_active,
    output logic             load_ack
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             load_ack_q, load_ack_d;
    logic [CNT_W-1:0] half, hi_last, lo_last;
    logic             boundary;

    // Phase lengths: high = ceil(N/2), low = floor(N/2); N >= 2 keeps both nonzero.
    always_comb begin
        half    = div_active_q >> 1;
        hi_last = div_active_q[0] ? half : half - CNT_W'(1);
        lo_last = half - CNT_W'(1);
    end

    assign boundary = (state_q == IDLE) || ((state_q == LOW) && (cnt_q == lo_last));

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (cnt_q == hi_last) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOW: begin
                if (cnt_q == lo_last) begin
                    state_d = en ? HIGH : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A load in the boundary cycle lands in the shadow and waits for the next boundary.
    always_comb begin
        div_active_d = div_active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        if (boundary && pending_q) begin
            div_active_d = shadow_q;
            pending_d    = 1'b0;
        end
        if (div_load) begin
            shadow_d  = CNT_W'(clamp_div(32'(div)));
            pending_d = 1'b1;
        end
        clk_out_d  = (state_q == HIGH);
        tick_d     = (state_q == HIGH) && !clk_out_q;
        load_ack_d = boundary && pending_q;
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            div_active_q <= CNT_W'(DIV_DEFAULT);
            shadow_q     <= CNT_W'(DIV_DEFAULT);
            pending_q    <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            div_active_q <= div_active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            load_ack_q   <= load_ack_d;
        end
    end

    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign div_active = div_active_q;
    assign load_ack   = load_ack_q;

endmodule
